bus_arbiter: RTL and testbench

//  Shares one single-ported memory bus between instruction fetch (IF port) and data access (MEM port).

---
 rtl/bus_arbiter_pkg.sv | 14 +
 rtl/bus_arbiter_port_hold.sv | 55 +++++
 rtl/bus_arbiter.sv | 172 +++++++++++++++++
 tb/tb_bus_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared state encoding and stall-vector indices for the instruction/data bus arbiter.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_IBUSY = 2'd1,
    ARB_DBUSY = 2'd2
  } arb_state_e;

  localparam int         STALL_IF_IDX  = 1;
  localparam int         STALL_MEM_IDX = 4;
  localparam logic [3:0] SEL_ALL       = 4'hF;

endpackage

// File: rtl/bus_arbiter_port_hold.sv
// Per-port completion flag and result register; the result stays put until the pipeline
// consumes it, and a timeout abort leaves zero in the register.
module bus_arbiter_port_hold #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_i,
  input  logic              hold_i,
  input  logic              flush_i,
  input  logic              fin_i,
  input  logic              tmo_i,
  input  logic              capture_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              done_o,
  output logic [DATA_W-1:0] data_o
);

  logic              done_q, done_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    done_d = done_q;
    data_d = data_q;
    if (done_q && (!hold_i || !ce_i)) begin
      done_d = 1'b0;
    end
    // A request withdrawn mid-cycle gets neither a done flag nor a new result.
    if (fin_i && ce_i) begin
      done_d = 1'b1;
      if (tmo_i) begin
        data_d = '0;
      end else if (capture_i) begin
        data_d = rdata_i;
      end
    end
    if (flush_i) begin
      done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q <= 1'b0;
      data_q <= '0;
    end else begin
      done_q <= done_d;
      data_q <= data_d;
    end
  end

  assign done_o = done_q;
  assign data_o = data_q;

endmodule

// File: rtl/bus_arbiter.sv
// Shares one single-ported memory bus between fetch and data ports, one bus cycle at a time.
// Data wins ties; a cycle with no ack within TIMEOUT cycles aborts and pulses bus_err_o.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall_i,
  input  logic              flush_i,
  input  logic              if_ce_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_data_o,
  output logic              if_stallreq_o,
  input  logic              d_ce_i,
  input  logic              d_we_i,
  input  logic [3:0]        d_sel_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_data_i,
  output logic [DATA_W-1:0] d_data_o,
  output logic              d_stallreq_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [3:0]        bus_sel_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_ack_i,
  output logic              bus_err_o
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] CNT_MAX = (TIMEOUT == 0) ? {TO_W{1'b1}} : TO_W'(TIMEOUT);

  arb_state_e        state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [3:0]        sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic              discard_q, discard_d;
  logic              err_q, err_d;
  logic              tmo, fin, keep, if_fin, d_fin;
  logic              if_done, d_done;
  logic              stall_unused;

  assign stall_unused = ^{stall_i[5], stall_i[3:2], stall_i[0]};

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    sel_d     = sel_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    discard_d = discard_q;
    err_d     = 1'b0;
    tmo       = 1'b0;
    fin       = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (d_ce_i && !d_done) begin
          state_d   = ARB_DBUSY;
          req_d     = 1'b1;
          we_d      = d_we_i;
          sel_d     = d_sel_i;
          addr_d    = d_addr_i;
          wdata_d   = d_data_i;
          cnt_d     = '0;
          discard_d = flush_i;
        end else if (if_ce_i && !if_done) begin
          state_d   = ARB_IBUSY;
          req_d     = 1'b1;
          we_d      = 1'b0;
          sel_d     = SEL_ALL;
          addr_d    = if_addr_i;
          wdata_d   = '0;
          cnt_d     = '0;
          discard_d = flush_i;
        end
      end
      ARB_IBUSY, ARB_DBUSY: begin
        // Flushed cycles still run to completion; only their result is dropped.
        tmo       = (TIMEOUT != 0) && (cnt_q == TO_LAST) && !bus_ack_i;
        fin       = bus_ack_i || tmo;
        discard_d = discard_q || flush_i;
        cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + TO_W'(1);
        if (fin) begin
          state_d = ARB_IDLE;
          req_d   = 1'b0;
          err_d   = tmo;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ARB_IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      discard_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      discard_q <= discard_d;
      err_q     <= err_d;
    end
  end

  assign keep   = !discard_q && !flush_i;
  assign if_fin = fin && keep && (state_q == ARB_IBUSY);
  assign d_fin  = fin && keep && (state_q == ARB_DBUSY);

  bus_arbiter_port_hold #(.DATA_W(DATA_W)) u_if_hold (
    .clk      (clk),
    .rst      (rst),
    .ce_i     (if_ce_i),
    .hold_i   (stall_i[STALL_IF_IDX]),
    .flush_i  (flush_i),
    .fin_i    (if_fin),
    .tmo_i    (tmo),
    .capture_i(1'b1),
    .rdata_i  (bus_rdata_i),
    .done_o   (if_done),
    .data_o   (if_data_o)
  );

  bus_arbiter_port_hold #(.DATA_W(DATA_W)) u_d_hold (
    .clk      (clk),
    .rst      (rst),
    .ce_i     (d_ce_i),
    .hold_i   (stall_i[STALL_MEM_IDX]),
    .flush_i  (flush_i),
    .fin_i    (d_fin),
    .tmo_i    (tmo),
    .capture_i(!we_q),
    .rdata_i  (bus_rdata_i),
    .done_o   (d_done),
    .data_o   (d_data_o)
  );

  assign if_stallreq_o = if_ce_i && !if_done;
  assign d_stallreq_o  = d_ce_i && !d_done;
  assign bus_req_o     = req_q;
  assign bus_we_o      = we_q;
  assign bus_sel_o     = sel_q;
  assign bus_addr_o    = addr_q;
  assign bus_wdata_o   = wdata_q;
  assign bus_err_o     = err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed and randomized accesses against a transaction-level memory model and a bus slave with
// programmable wait states; TIMEOUT is shortened so aborts are reachable.
module tb_bus_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  stall_i = '0;
  logic        flush_i = 1'b0;
  logic        if_ce_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic [31:0] if_data_o;
  logic        if_stallreq_o;
  logic        d_ce_i = 1'b0;
  logic        d_we_i = 1'b0;
  logic [3:0]  d_sel_i = '0;
  logic [31:0] d_addr_i = '0;
  logic [31:0] d_data_i = '0;
  logic [31:0] d_data_o;
  logic        d_stallreq_o;
  logic        bus_req_o, bus_we_o, bus_err_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [31:0] bus_rdata_i = '0;
  logic        bus_ack_i = 1'b0;

  always #5 clk = ~clk;

  bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO), .TO_W(8)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_stallreq_o(if_stallreq_o),
    .d_ce_i(d_ce_i), .d_we_i(d_we_i), .d_sel_i(d_sel_i), .d_addr_i(d_addr_i), .d_data_i(d_data_i),
    .d_data_o(d_data_o), .d_stallreq_o(d_stallreq_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i), .bus_err_o(bus_err_o)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdata;
    int          start;
  } cyc_t;

  cyc_t        log_q[$];
  logic [31:0] slv_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  int          ws_cfg = 0;
  int          in_cyc = 0;
  int          req_cyc = 0;
  int          err_cnt = 0;
  int          ncnt = 0;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] m_if = '0;
  logic [31:0] m_d = '0;

  function automatic logic [31:0] init_pat(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] slv_rd(input logic [31:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : init_pat(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_pat(a);
  endfunction

  // Bus slave: acks in the (ws_cfg+1)-th cycle of bus_req_o and logs every bus cycle.
  always @(negedge clk) begin
    ncnt <= ncnt + 1;
    if (bus_err_o) err_cnt <= err_cnt + 1;
    if (!rst || !bus_req_o) begin
      in_cyc    <= 0;
      bus_ack_i <= 1'b0;
    end else begin
      req_cyc <= req_cyc + 1;
      if (in_cyc == 0) log_q.push_back('{bus_addr_o, bus_we_o, bus_sel_o, bus_wdata_o, ncnt + 1});
      in_cyc <= in_cyc + 1;
      if (in_cyc == ws_cfg) begin
        bus_ack_i   <= 1'b1;
        bus_rdata_i <= bus_we_o ? 32'h0 : slv_rd(bus_addr_o);
        if (bus_we_o) slv_mem[bus_addr_o] = merge(slv_rd(bus_addr_o), bus_wdata_o, bus_sel_o);
      end else begin
        bus_ack_i <= 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic release_ports();
    if_ce_i = 1'b0;
    d_ce_i  = 1'b0;
    d_we_i  = 1'b0;
    stall_i = '0;
    flush_i = 1'b0;
    @(negedge clk);
  endtask

  // kind: 0 fetch, 1 load, 2 store.  ws: wait cycles before ack (>= TO means never acked).
  task automatic access(input int kind, input logic [31:0] addr, input logic [31:0] wdat,
                        input logic [3:0] sel, input int ws);
    int busy, n, err0, req0;
    bit tmo;
    tmo  = (ws >= TO);
    busy = tmo ? TO : ws + 1;
    if (kind == 0) m_if = tmo ? 32'h0 : ref_rd(addr);
    else if (kind == 1) m_d = tmo ? 32'h0 : ref_rd(addr);
    else if (tmo) m_d = 32'h0;
    else ref_mem[addr] = merge(ref_rd(addr), wdat, sel);
    @(negedge clk);
    ws_cfg = ws;
    log_q.delete();
    err0 = err_cnt;
    req0 = req_cyc;
    stall_i = 6'h3F;
    if (kind == 0) begin
      if_ce_i = 1'b1; if_addr_i = addr;
    end else begin
      d_ce_i = 1'b1; d_we_i = (kind == 2); d_sel_i = sel; d_addr_i = addr; d_data_i = wdat;
    end
    n = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!((kind == 0) ? if_stallreq_o : d_stallreq_o)) break;
      n++;
      @(negedge clk);
    end
    check("stall_cycles", 32'(n), 32'(busy + 1));
    check("req_cycles", 32'(req_cyc - req0), 32'(busy));
    check("err_pulses", 32'(err_cnt - err0), 32'(tmo));
    check("bus_cycles", 32'(log_q.size()), 32'd1);
    if (log_q.size() > 0) begin
      check("bus_addr", log_q[0].addr, addr);
      check("bus_we", 32'(log_q[0].we), 32'(kind == 2));
      check("bus_sel", 32'(log_q[0].sel), (kind == 0) ? 32'hF : 32'(sel));
      if (kind == 2) check("bus_wdata", log_q[0].wdata, wdat);
    end
    check("if_data", if_data_o, m_if);
    check("d_data", d_data_o, m_d);
    release_ports();
  endtask

  task automatic both(input logic [31:0] iaddr, input logic [31:0] daddr, input int ws);
    int d_low;
    m_d  = ref_rd(daddr);
    m_if = ref_rd(iaddr);
    @(negedge clk);
    ws_cfg = ws;
    log_q.delete();
    stall_i = 6'h3F;
    if_ce_i = 1'b1; if_addr_i = iaddr;
    d_ce_i = 1'b1; d_we_i = 1'b0; d_sel_i = 4'hF; d_addr_i = daddr;
    d_low = -1;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (d_low < 0 && !d_stallreq_o) d_low = ncnt;
      if (!if_stallreq_o) break;
      @(negedge clk);
    end
    check("tie_cycles", 32'(log_q.size()), 32'd2);
    if (log_q.size() == 2) begin
      check("tie_first_data", log_q[0].addr, daddr);
      check("tie_then_fetch", log_q[1].addr, iaddr);
      check("tie_fetch_start", 32'(log_q[1].start), 32'(d_low + 1));
    end
    check("tie_if_data", if_data_o, m_if);
    check("tie_d_data", d_data_o, m_d);
    check("tie_d_stallreq", 32'(d_stallreq_o), 32'd0);
    release_ports();
  endtask

  initial begin
    int n, req0, kind, ws;
    logic [31:0] mid, old;

    repeat (3) @(negedge clk);
    #1;
    check("rst_bus_req", 32'(bus_req_o), 32'd0);
    check("rst_bus_we", 32'(bus_we_o), 32'd0);
    check("rst_bus_sel", 32'(bus_sel_o), 32'd0);
    check("rst_bus_addr", bus_addr_o, 32'd0);
    check("rst_bus_wdata", bus_wdata_o, 32'd0);
    check("rst_if_data", if_data_o, 32'd0);
    check("rst_d_data", d_data_o, 32'd0);
    check("rst_bus_err", 32'(bus_err_o), 32'd0);
    check("rst_stallreqs", 32'({if_stallreq_o, d_stallreq_o}), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    slv_mem[32'h100] = 32'h3C010001;
    ref_mem[32'h100] = 32'h3C010001;
    access(0, 32'h100, 32'h0, 4'hF, 0);
    access(0, 32'h100, 32'h0, 4'hF, 0);
    both(32'h104, 32'h200, 1);
    access(2, 32'h200, 32'hDEADBEEF, 4'b0011, 1);
    access(1, 32'h200, 32'h0, 4'hF, 0);
    access(1, 32'h280, 32'h0, 4'hF, 5);
    access(1, 32'h284, 32'h0, 4'hF, 3);

    // Flush during the first of two cycles: it completes, is discarded, and the request reruns.
    old = m_d;
    m_d = ref_rd(32'h108);
    mid = ~old;
    @(negedge clk);
    ws_cfg = 3; log_q.delete(); req0 = req_cyc;
    stall_i = 6'h3F; d_ce_i = 1'b1; d_we_i = 1'b0; d_sel_i = 4'hF; d_addr_i = 32'h108;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (n == 5) mid = d_data_o;
      if (!d_stallreq_o) break;
      n++;
      flush_i = (n == 2);
      @(negedge clk);
    end
    check("flush_stall_cycles", 32'(n), 32'd10);
    check("flush_req_cycles", 32'(req_cyc - req0), 32'd8);
    check("flush_bus_cycles", 32'(log_q.size()), 32'd2);
    check("flush_hold_unchanged", mid, old);
    check("flush_rerun_data", d_data_o, m_d);
    release_ports();

    // Reset in the middle of a data cycle, then the still-held request restarts.
    @(negedge clk);
    ws_cfg = 5; log_q.delete();
    stall_i = 6'h3F; d_ce_i = 1'b1; d_we_i = 1'b0; d_sel_i = 4'hF; d_addr_i = 32'h300;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_bus_req", 32'(bus_req_o), 32'd0);
    check("mid_rst_bus_addr", bus_addr_o, 32'd0);
    check("mid_rst_bus_sel", 32'(bus_sel_o), 32'd0);
    check("mid_rst_d_data", d_data_o, 32'd0);
    check("mid_rst_if_data", if_data_o, 32'd0);
    m_if = 32'h0;
    m_d  = ref_rd(32'h300);
    @(negedge clk);
    ws_cfg = 1; log_q.delete(); rst = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!d_stallreq_o) break;
      n++;
      @(negedge clk);
    end
    check("restart_stall_cycles", 32'(n), 32'd3);
    check("restart_bus_cycles", 32'(log_q.size()), 32'd1);
    if (log_q.size() > 0) check("restart_addr", log_q[0].addr, 32'h300);
    check("restart_d_data", d_data_o, m_d);
    release_ports();

    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 2);
      ws = ($urandom_range(0, 9) == 0) ? 4 + $urandom_range(0, 1) : $urandom_range(0, 3);
      access(kind, 32'h400 + 32'($urandom_range(0, 7)) * 4, $urandom, 4'($urandom_range(1, 15)), ws);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
